// File: rtl/paddle_input_ctrl_if.sv
// Bundle of player inputs and conditioned paddle outputs for paddle_input_ctrl.
// The hps_io side is the master; the conditioner is the slave.
interface paddle_input_ctrl_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned POS_W  = 8
);
  logic [3*NUM_CH-1:0]     mode;
  logic [16*NUM_CH-1:0]    joystick_analog;
  logic [8*NUM_CH-1:0]     paddle;
  logic [NUM_CH-1:0]       joy_up;
  logic [NUM_CH-1:0]       joy_down;
  logic                    vsync;
  logic [POS_W*NUM_CH-1:0] pos_out;
  logic                    pos_valid;

  modport master (
    output mode, joystick_analog, paddle, joy_up, joy_down, vsync,
    input  pos_out, pos_valid
  );

  modport slave (
    input  mode, joystick_analog, paddle, joy_up, joy_down, vsync,
    output pos_out, pos_valid
  );
endinterface

// File: rtl/paddle_input_ctrl.sv
// Per-player paddle conditioner: one channel updated per clock after each vsync rise.
// Optional analog dead band for modes 0-2 enabled by defining PADDLE_DEADZONE_EN.
module paddle_input_ctrl #(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned POS_W        = 8,
  parameter int unsigned RAMP_STEP    = 4,
  parameter int unsigned ACCEL_FRAMES = 8,
  parameter int unsigned MAX_SLEW     = 0,
  parameter int unsigned DEADZONE     = 6
) (
  input logic                clk_sys,
  input logic                reset_n,
  paddle_input_ctrl_if.slave bus
);

  localparam int unsigned ChW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [POS_W-1:0] PosMid = {1'b1, {(POS_W-1){1'b0}}};
  localparam logic [POS_W-1:0] SlewW  = POS_W'(MAX_SLEW);

  typedef enum logic [1:0] {StIdle, StUpd, StDone} state_e;

  state_e         state_q, state_d;
  logic [ChW-1:0] ch_q, ch_d;
  logic           vsync_dly_q, vsync_dly_d;
  logic           rise;

  logic [POS_W-1:0] pos_q       [NUM_CH];
  logic [POS_W-1:0] pos_d       [NUM_CH];
  logic [7:0]       ramp_q      [NUM_CH];
  logic [7:0]       ramp_d      [NUM_CH];
  logic [7:0]       hold_q      [NUM_CH];
  logic [7:0]       hold_d      [NUM_CH];
  logic [2:0]       mode_last_q [NUM_CH];
  logic [2:0]       mode_last_d [NUM_CH];

  // Datapath for the channel selected by ch_q
  logic [2:0]       sel_mode_raw, sel_mode, sel_mode_last;
  logic [15:0]      sel_joy;
  logic [7:0]       sel_pad, sel_ramp, sel_hold;
  logic             sel_up, sel_dn;
  logic [POS_W-1:0] sel_pos;
  logic [1:0]       accel;
  logic [10:0]      step, ramp_sum;
  logic [7:0]       ramp_new, hold_new, t8;
  logic [POS_W-1:0] tgt, pos_new;
`ifdef PADDLE_DEADZONE_EN
  logic signed [9:0] dev, dz;
`endif

  assign vsync_dly_d = bus.vsync;
  assign rise        = bus.vsync & ~vsync_dly_q;

  // State register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      ch_q        <= '0;
      vsync_dly_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      vsync_dly_q <= vsync_dly_d;
    end
  end

  // Next-state logic; a rise outside StIdle is dropped
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    unique case (state_q)
      StIdle: begin
        if (rise) begin
          state_d = StUpd;
          ch_d    = '0;
        end
      end
      StUpd: begin
        if (ch_q == ChW'(NUM_CH - 1)) state_d = StDone;
        else                          ch_d    = ch_q + 1'b1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    bus.pos_valid = (state_q == StDone);
    bus.pos_out   = '0;
    for (int i = 0; i < NUM_CH; i++) bus.pos_out[POS_W*i +: POS_W] = pos_q[i];
  end

  always_comb begin
    sel_mode_raw  = '0;
    sel_mode_last = '0;
    sel_joy       = '0;
    sel_pad       = '0;
    sel_ramp      = '0;
    sel_hold      = '0;
    sel_up        = 1'b0;
    sel_dn        = 1'b0;
    sel_pos       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_q == ChW'(i)) begin
        sel_mode_raw  = bus.mode[3*i +: 3];
        sel_mode_last = mode_last_q[i];
        sel_joy       = bus.joystick_analog[16*i +: 16];
        sel_pad       = bus.paddle[8*i +: 8];
        sel_ramp      = ramp_q[i];
        sel_hold      = hold_q[i];
        sel_up        = bus.joy_up[i];
        sel_dn        = bus.joy_down[i];
        sel_pos       = pos_q[i];
      end
    end
    sel_mode = (sel_mode_raw > 3'd4) ? 3'd0 : sel_mode_raw;
  end

  // Digital ramp with acceleration and bumpless entry into mode 4
  always_comb begin
    if (32'(sel_hold) >= 2 * ACCEL_FRAMES)  accel = 2'd2;
    else if (32'(sel_hold) >= ACCEL_FRAMES) accel = 2'd1;
    else                                    accel = 2'd0;
    step     = 11'(RAMP_STEP) << accel;
    ramp_sum = {3'b000, sel_ramp} + step;
    ramp_new = sel_ramp;
    hold_new = sel_hold;
    if (sel_mode == 3'd4) begin
      if (sel_mode != sel_mode_last) begin
        ramp_new = sel_pos[POS_W-1 -: 8];
        hold_new = 8'd0;
      end else if (sel_up != sel_dn) begin
        hold_new = (sel_hold == 8'hFF) ? 8'hFF : sel_hold + 8'd1;
        if (sel_up) ramp_new = (ramp_sum > 11'd255) ? 8'hFF : ramp_sum[7:0];
        else        ramp_new = (step >= {3'b000, sel_ramp}) ? 8'h00 : sel_ramp - step[7:0];
      end else begin
        hold_new = 8'd0;
      end
    end
  end

  // Target selection, width expansion and slew limiting
  always_comb begin
    unique case (sel_mode)
      3'd0:    t8 = sel_joy[15:8] + 8'h80;
      3'd1:    t8 = sel_joy[7:0] + 8'h80;
      3'd2:    t8 = sel_joy[7:0] ^ 8'h7F;
      3'd3:    t8 = sel_pad;
      default: t8 = ramp_new;
    endcase
`ifdef PADDLE_DEADZONE_EN
    dev = $signed({2'b00, t8}) - 10'sd128;
    dz  = $signed(10'(DEADZONE));
    if ((sel_mode <= 3'd2) && (dev <= dz) && (dev >= -dz)) t8 = 8'h80;
`endif
    // Replicate the top bits of t8 into the extra LSBs
    for (int b = 0; b < POS_W; b++) tgt[POS_W-1-b] = t8[7 - (b % 8)];
    pos_new = tgt;
    if (MAX_SLEW != 0) begin
      if (tgt > sel_pos) begin
        if (32'(tgt - sel_pos) > MAX_SLEW) pos_new = sel_pos + SlewW;
      end else if (32'(sel_pos - tgt) > MAX_SLEW) begin
        pos_new = sel_pos - SlewW;
      end
    end
  end

  always_comb begin
    pos_d       = pos_q;
    ramp_d      = ramp_q;
    hold_d      = hold_q;
    mode_last_d = mode_last_q;
    if (state_q == StUpd) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_q == ChW'(i)) begin
          pos_d[i]       = pos_new;
          ramp_d[i]      = ramp_new;
          hold_d[i]      = hold_new;
          mode_last_d[i] = sel_mode;
        end
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        pos_q[i]       <= PosMid;
        ramp_q[i]      <= 8'h80;
        hold_q[i]      <= 8'h00;
        mode_last_q[i] <= 3'd0;
      end
    end else begin
      pos_q       <= pos_d;
      ramp_q      <= ramp_d;
      hold_q      <= hold_d;
      mode_last_q <= mode_last_d;
    end
  end

endmodule

// File: doc/paddle_input_ctrl.md
Name: paddle_input_ctrl

Overview:
Generalised per-player paddle-position conditioner between hps_io and the game core. Replaces the fixed two-player combinational paddle mux with NUM_CH channels and selectable source modes, including a digital-joystick ramp mode with acceleration. Adds per-frame slew limiting and frame-synchronous output updates. Channels are processed sequentially, one per clock, after each vsync rising edge.

Parameters:
NUM_CH, 2, number of player channels (1..8)
POS_W, 8, output position width (8..16)
RAMP_STEP, 4, base digital-mode step per frame, in 8-bit units
ACCEL_FRAMES, 8, consecutive held frames before the step doubles
MAX_SLEW, 0, maximum output change per frame in POS_W units; 0 = unlimited
DEADZONE, 6, analog centre dead band in 8-bit units (used only with the optional feature)

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
mode  in  3*NUM_CH  per-channel source select: 0 Y, 1 X, 2 Inv-X, 3 Paddle, 4 Digital; 5-7 treated as 0
joystick_analog  in  16*NUM_CH  per channel: [15:8] Y, [7:0] X, signed
paddle  in  8*NUM_CH  per-channel raw paddle value, unsigned
joy_up  in  NUM_CH  digital up, per channel
joy_down  in  NUM_CH  digital down, per channel
vsync  in  1  frame strobe, already in the clk_sys domain
pos_out  out  POS_W*NUM_CH  conditioned positions
pos_valid  out  1  one-cycle pulse when all channels have been updated

Behaviour:
- Async reset (reset_n=0):
  - each pos_out slice = 2^(POS_W-1)
  - ramp counters = 8'h80; hold counters = 0
  - FSM = IDLE; pos_valid = 0; vs_d = 0
- Edge detect: vs_d <= vsync every clock; rise = vsync & ~vs_d.
- FSM:
  - IDLE: on rise, go to UPD with ch = 0.
  - UPD: process channel ch. If ch = NUM_CH-1, go to DONE; otherwise ch++.
  - DONE: assert pos_valid for exactly one cycle, then go to IDLE.
  - Latency: pos_valid is high NUM_CH+1 cycles after the rise cycle.
  - A rise during UPD or DONE is ignored; that frame is dropped.
- 8-bit target t8 per mode:
  - 0 Y: Y + 8'h80
  - 1 X: X + 8'h80
  - 2 Inv-X: X ^ 8'h7F
  - 3 Paddle: paddle unchanged
  - 4 Digital: ramp counter
- Digital ramp (evaluated in UPD, one step per frame):
  - up only: ramp += step, saturating at 255
  - down only: ramp -= step, saturating at 0
  - step = RAMP_STEP << min(hold/ACCEL_FRAMES, 2), i.e. capped at 4x
  - hold increments, saturating, while exactly one of up/down is held
  - neither or both held: ramp unchanged, hold = 0
- Bumpless transfer: when a channel's mode changes to 4 (mode differs from its last-seen mode register), ramp loads from the top 8 bits of the current pos_out and no step is applied that frame.
- Width expansion: target = {t8, t8[7 -: POS_W-8]} (top bits replicated into the LSBs); for POS_W = 8 the target is t8.
- Slew (MAX_SLEW != 0): pos_out moves toward the target by min(|target - pos|, MAX_SLEW), using unsigned compare with no wrap. With MAX_SLEW = 0, pos_out = target.
- pos_out slices change only in their UPD cycle and are stable otherwise.

Optional Feature:
- PADDLE_DEADZONE_EN defined:
  - modes 0-2 only: if the signed deflection (t8 - 8'h80) lies within [-DEADZONE, +DEADZONE], t8 is forced to 8'h80
  - modes 3 and 4 are unaffected
- Undefined: no dead band, and the DEADZONE parameter is ignored.

Test Plan:
1. Reset: reset_n=0 mid-UPD with POS_W=8 -> all pos_out=8'h80 immediately, pos_valid=0; after release with no vsync -> outputs unchanged.
2. Modes, NUM_CH=2: ch0 mode 0 with Y=8'h10 -> 8'h90; ch1 mode 2 with X=8'h10 -> 8'h6F; pos_valid pulses exactly 3 cycles after the rise.
3. Digital: mode 4, up held, RAMP_STEP=4, ACCEL_FRAMES=8 -> frames 1-8 +4 each (0x84..0xA0), frames 9-16 +8, then +16 steps, saturating at 0xFF; up and down both held -> value holds, acceleration resets.
4. Bumpless transfer: pos 0x37 in mode 3, then switch to mode 4 with no buttons -> next frame output stays 0x37; with up held -> 0x3B the frame after.
5. Slew: MAX_SLEW=16, paddle steps 0x00 -> 0xFF -> successive frames 0x10, 0x20, ..., reaching 0xFF on frame 16; POS_W=10 with paddle=0xFF -> target 10'h3FF.
6. Deadzone, macro on with DEADZONE=6: Y=+5 -> 8'h80; Y=+7 -> 8'h87; mode 3 with paddle=0x82 -> 0x82. Macro off: Y=+5 -> 8'h85.
